// File: rtl/button_conditioner.sv
// Multi-channel button synchronizer, debouncer and press/release pulse generator.
// Define BUTTON_AUTO_REPEAT_EN to add per-channel auto-repeat of button_down.
module button_conditioner #(
  parameter int N_BUTTONS       = 5,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 500,
  parameter int REPEAT_PERIOD   = 100
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [N_BUTTONS-1:0] button,
  output logic [N_BUTTONS-1:0] button_state,
  output logic [N_BUTTONS-1:0] button_down,
  output logic [N_BUTTONS-1:0] button_up,
  output logic                 any_down
);

  localparam int DW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES - 1);

  logic [N_BUTTONS-1:0] sync_q1;
  logic [N_BUTTONS-1:0] sync_q2;
  logic [DW-1:0]        db_cnt [N_BUTTONS];
  logic [N_BUTTONS-1:0] toggle;
  logic [N_BUTTONS-1:0] rise;
  logic [N_BUTTONS-1:0] fall;
  logic [N_BUTTONS-1:0] down_next;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= button;
      sync_q2 <= sync_q1;
    end
  end

  always_comb begin
    toggle = '0;
    for (int i = 0; i < N_BUTTONS; i++) begin
      toggle[i] = (sync_q2[i] != button_state[i]) &&
                  (db_cnt[i] == DB_MAX);
    end
  end

  assign rise = toggle & ~button_state;
  assign fall = toggle & button_state;

  // Counter only runs while the synchronized level disagrees.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_BUTTONS; i++) begin
        db_cnt[i] <= '0;
      end
      button_state <= '0;
    end else begin
      for (int i = 0; i < N_BUTTONS; i++) begin
        if (sync_q2[i] == button_state[i] || toggle[i]) begin
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
      button_state <= button_state ^ toggle;
    end
  end

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam int RMAX =
    (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);
  localparam logic [RW-1:0] RD_LOAD = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LOAD = RW'(REPEAT_PERIOD - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DELAY  = 2'd1;
  localparam logic [1:0] S_REPEAT = 2'd2;

  logic [1:0]           rpt_state [N_BUTTONS];
  logic [RW-1:0]        rpt_cnt   [N_BUTTONS];
  logic [N_BUTTONS-1:0] rpt_fire;

  always_comb begin
    rpt_fire = '0;
    for (int i = 0; i < N_BUTTONS; i++) begin
      rpt_fire[i] = (rpt_state[i] != S_IDLE) &&
                    (rpt_cnt[i] == '0);
    end
  end

  // Release has priority over a repeat due on the same edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_BUTTONS; i++) begin
        rpt_state[i] <= S_IDLE;
        rpt_cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N_BUTTONS; i++) begin
        unique case (1'b1)
          fall[i]: begin
            rpt_state[i] <= S_IDLE;
            rpt_cnt[i]   <= '0;
          end
          rise[i]: begin
            rpt_state[i] <= S_DELAY;
            rpt_cnt[i]   <= RD_LOAD;
          end
          rpt_fire[i]: begin
            rpt_state[i] <= S_REPEAT;
            rpt_cnt[i]   <= RP_LOAD;
          end
          default: begin
            if (rpt_state[i] != S_IDLE) begin
              rpt_cnt[i] <= rpt_cnt[i] - 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign down_next = rise | (rpt_fire & ~fall);
`else
  logic [63:0] unused_cfg;
  assign unused_cfg = {32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
  assign down_next  = rise;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      button_down <= '0;
      button_up   <= '0;
      any_down    <= 1'b0;
    end else begin
      button_down <= down_next;
      button_up   <= fall;
      any_down    <= |down_next;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomized and directed bench for button_conditioner against a
// cycle-count reference model (N=5, debounce 4, delay 10, period 5).
module tb_button_conditioner;

  localparam int NB = 5;
  localparam int DC = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  logic          clock;
  logic          reset_n;
  logic [NB-1:0] button;
  logic [NB-1:0] button_state;
  logic [NB-1:0] button_down;
  logic [NB-1:0] button_up;
  logic          any_down;

  int tests_run;
  int tests_failed;

  button_conditioner #(
    .N_BUTTONS      (NB),
    .DEBOUNCE_CYCLES(DC),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .button      (button),
    .button_state(button_state),
    .button_down (button_down),
    .button_up   (button_up),
    .any_down    (any_down)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: raw sample history, run length of disagreement,
  // and age since the press pulse for repeat timing.
  logic [NB-1:0] m_h1, m_h2, m_st, m_dn, m_up, m_held;
  logic          m_any;
  int            m_run [NB];
  int            m_age [NB];

  initial begin
    m_h1 = '0; m_h2 = '0; m_st = '0; m_dn = '0;
    m_up = '0; m_held = '0; m_any = 1'b0;
    for (int i = 0; i < NB; i++) begin
      m_run[i] = 0;
      m_age[i] = 0;
    end
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) begin
        m_h1 = '0; m_h2 = '0; m_st = '0; m_dn = '0;
        m_up = '0; m_held = '0; m_any = 1'b0;
        for (int i = 0; i < NB; i++) begin
          m_run[i] = 0;
          m_age[i] = 0;
        end
      end else begin
        for (int i = 0; i < NB; i++) begin
          m_dn[i] = 1'b0;
          m_up[i] = 1'b0;
          if (m_h2[i] != m_st[i]) m_run[i] = m_run[i] + 1;
          else m_run[i] = 0;
          if (m_run[i] == DC) begin
            m_run[i] = 0;
            m_st[i]  = ~m_st[i];
            if (m_st[i]) begin
              m_dn[i]   = 1'b1;
              m_age[i]  = 0;
              m_held[i] = 1'b1;
            end else begin
              m_up[i]   = 1'b1;
              m_held[i] = 1'b0;
            end
          end else if (m_held[i]) begin
            m_age[i] = m_age[i] + 1;
`ifdef BUTTON_AUTO_REPEAT_EN
            if (m_age[i] >= RD && (m_age[i] - RD) % RP == 0)
              m_dn[i] = 1'b1;
`endif
          end
        end
        m_any = |m_dn;
        m_h2  = m_h1;
        m_h1  = button;
      end
    end
  end

  logic [3*NB:0] act_v, exp_v;
  assign act_v = {button_state, button_down, button_up, any_down};
  assign exp_v = {m_st, m_dn, m_up, m_any};

  task test_reset;
    reset_n = 1'b0;
    button  = '0;
    repeat (3) @(negedge clock);
    tests_run++;
    if (act_v !== '0) begin
      tests_failed++;
      $display("FAIL reset_held got %h want 0", act_v);
    end
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      tests_run++;
      if (act_v !== '0) begin
        tests_failed++;
        $display("FAIL reset_idle k=%0d got %h want 0", k, act_v);
      end
    end
  endtask

  task test_clean_press;
    int first;
    first = -1;
    button[0] = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clock);
      tests_run++;
      if (act_v !== exp_v) begin
        tests_failed++;
        $display("FAIL clean_press k=%0d got %h want %h", k, act_v, exp_v);
      end
      if (button_down[0] && first < 0) first = k;
      if (button_up !== '0) begin
        tests_failed++;
        $display("FAIL clean_press_up k=%0d got %b want 0", k, button_up);
      end
    end
    tests_run++;
    if (first != DC + 1) begin
      tests_failed++;
      $display("FAIL clean_press_lat got %0d want %0d", first, DC + 1);
    end
    button[0] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      tests_run++;
      if (act_v !== exp_v) begin
        tests_failed++;
        $display("FAIL clean_rel k=%0d got %h want %h", k, act_v, exp_v);
      end
    end
  endtask

  task test_glitch;
    button[2] = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clock);
      if (k == 2) button[2] = 1'b0;
      tests_run++;
      if ({button_state[2], button_down[2], button_up[2]} !== 3'b000) begin
        tests_failed++;
        $display("FAIL glitch k=%0d got %b%b%b want 000", k,
                 button_state[2], button_down[2], button_up[2]);
      end
    end
  endtask

`ifdef BUTTON_AUTO_REPEAT_EN
  task test_repeat;
    int p, up_at, nd;
    int got [$];
    int want [8];
    bit bad;
    p = -1; up_at = -1; bad = 0;
    want = '{0, 10, 15, 20, 25, 30, 35, 40};
    button[1] = 1'b1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clock);
      tests_run++;
      if (act_v !== exp_v) begin
        tests_failed++;
        $display("FAIL repeat k=%0d got %h want %h", k, act_v, exp_v);
      end
      if (button_down[1]) begin
        if (p < 0) p = k;
        got.push_back(k - p);
      end
      if (button_up[1] && up_at < 0) up_at = k;
      if (p >= 0 && k == p + 39) button[1] = 1'b0;
    end
    nd = got.size();
    if (nd != 8) bad = 1;
    else for (int i = 0; i < 8; i++) if (got[i] != want[i]) bad = 1;
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL repeat_times got %0d pulses want 8 at P+0,10..40", nd);
    end
    tests_run++;
    if (up_at - p != 45) begin
      tests_failed++;
      $display("FAIL repeat_up got P+%0d want P+45", up_at - p);
    end
  endtask
`else
  task test_single_pulse;
    int nd;
    nd = 0;
    button[1] = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clock);
      if (k == 45) button[1] = 1'b0;
      tests_run++;
      if (act_v !== exp_v) begin
        tests_failed++;
        $display("FAIL single k=%0d got %h want %h", k, act_v, exp_v);
      end
      if (button_down[1]) nd++;
    end
    tests_run++;
    if (nd != 1) begin
      tests_failed++;
      $display("FAIL single_count got %0d want 1", nd);
    end
  endtask
`endif

  task test_simultaneous;
    button[4:3] = 2'b11;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      tests_run++;
      if (act_v !== exp_v) begin
        tests_failed++;
        $display("FAIL simul k=%0d got %h want %h", k, act_v, exp_v);
      end
      if (k == 5) begin
        tests_run++;
        if (button_down !== 5'b11000 || any_down !== 1'b1) begin
          tests_failed++;
          $display("FAIL simul_down got %b/%b want 11000/1",
                   button_down, any_down);
        end
      end
      if (k == 13) begin
        tests_run++;
        if (button_up !== 5'b01000) begin
          tests_failed++;
          $display("FAIL simul_up got %b want 01000", button_up);
        end
      end
      if (k == 7) button[3] = 1'b0;
      if (k == 25) button[4] = 1'b0;
    end
  endtask

  task test_reset_mid;
    button[0] = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clock);
      tests_run++;
      if (act_v !== exp_v) begin
        tests_failed++;
        $display("FAIL rstmid k=%0d got %h want %h", k, act_v, exp_v);
      end
      if (k == 2) begin
        tests_run++;
        if (act_v !== '0) begin
          tests_failed++;
          $display("FAIL rstmid_zero got %h want 0", act_v);
        end
      end
      if (k == 8) begin
        tests_run++;
        if (button_down[0] !== 1'b1) begin
          tests_failed++;
          $display("FAIL rstmid_press got %b want 1", button_down[0]);
        end
      end
      reset_n = (k == 1) ? 1'b0 : 1'b1;
    end
    button[0] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      tests_run++;
      if (act_v !== exp_v) begin
        tests_failed++;
        $display("FAIL rstmid_rel k=%0d got %h want %h", k, act_v, exp_v);
      end
    end
  endtask

  task test_random;
    int idx;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clock);
      tests_run++;
      if (act_v !== exp_v) begin
        tests_failed++;
        $display("FAIL random k=%0d got %h want %h", k, act_v, exp_v);
      end
      if ($urandom_range(0, 5) == 0) begin
        idx = $urandom_range(0, NB - 1);
        button[idx] = ~button[idx];
      end
      reset_n = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
    end
    reset_n = 1'b1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_n      = 1'b0;
    button       = '0;
    @(negedge clock);
    test_reset();
    test_clean_press();
    test_glitch();
`ifdef BUTTON_AUTO_REPEAT_EN
    test_repeat();
`else
    test_single_pulse();
`endif
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
